reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 101 ++++++++++
 tb/tb_reg_file_mp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised write ports, sequential clear after reset.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 32,
  parameter int AWIDTH   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [AWIDTH-1:0]        wa0,
  input  logic [DWIDTH-1:0]        wd0,
  input  logic                     we1,
  input  logic [AWIDTH-1:0]        wa1,
  input  logic [DWIDTH-1:0]        wd1,
  input  logic [NUM_RD*AWIDTH-1:0] ra,
  output logic [NUM_RD*DWIDTH-1:0] rd,
  output logic                     ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   clr_idx_q, clr_idx_d;
  logic                ready_q, ready_d;
  logic [DWIDTH-1:0]   mem_q [DEPTH];
  logic [DWIDTH-1:0]   mem_d [DEPTH];
  logic                wr0_ok, wr1_ok;

  // A write only lands in READY, and never on the hardwired-zero entry.
  always_comb begin
    wr0_ok = we0 && (state_q == READY) && !((ZERO_REG != 0) && (wa0 == '0));
    wr1_ok = we1 && (state_q == READY) && !((ZERO_REG != 0) && (wa1 == '0));
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    mem_d     = mem_q;
    case (state_q)
      CLEAR: begin
        mem_d[clr_idx_q] = '0;
        clr_idx_d        = clr_idx_q + AWIDTH'(1);
        if (clr_idx_q == AWIDTH'(DEPTH - 1)) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: begin
        ready_d = 1'b1;
        // Port 1 is applied last so it wins on an address collision.
        if (wr0_ok) mem_d[wa0] = wd0;
        if (wr1_ok) mem_d[wa1] = wd1;
      end
      default: begin
        state_d = CLEAR;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      mem_q     <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;

    assign addr = ra[k*AWIDTH +: AWIDTH];

    always_comb begin
      data = mem_q[addr];
`ifdef REG_FILE_MP_BYPASS_EN
      if (wr0_ok && (wa0 == addr)) data = wd0;
      if (wr1_ok && (wa1 == addr)) data = wd1;
`endif
      if (!ready_q || ((ZERO_REG != 0) && (addr == '0))) data = '0;
    end

    assign rd[k*DWIDTH +: DWIDTH] = data;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (default parameters): directed steps plus random traffic against an abstract array model.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int NRD   = 2;

  logic              clk = 1'b0;
  logic              rst, we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wd0, wd1;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic              ready;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            model_ready = 1'b0;
  int            clear_left  = DEPTH;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk   (clk),
    .rst   (rst),
    .we0   (we0),
    .wa0   (wa0),
    .wd0   (wd0),
    .we1   (we1),
    .wa1   (wa1),
    .wd1   (wd1),
    .ra    (ra),
    .rd    (rd),
    .ready (ready)
  );

  // Reference view: not ready until DEPTH clean cycles after reset, then a plain array with port 1 winning.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (!model_ready || a == '0) return '0;
`ifdef REG_FILE_MP_BYPASS_EN
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
`endif
    return model_mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      model_ready = 1'b0;
      clear_left  = DEPTH;
    end else if (!model_ready) begin
      clear_left--;
      if (clear_left == 0) begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_ready = 1'b1;
      end
    end else begin
      if (we0 && wa0 != '0) model_mem[wa0] = wd0;
      if (we1 && wa1 != '0) model_mem[wa1] = wd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic e1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1, input logic [NRD*AW-1:0] rav);
    rst = r;
    we0 = e0;
    wa0 = a0;
    wd0 = d0;
    we1 = e1;
    wa1 = a1;
    wd1 = d1;
    ra  = rav;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_ready"}, {31'b0, ready}, {31'b0, model_ready});
    for (int k = 0; k < NRD; k++)
      check($sformatf("%s_rd%0d", tag, k), rd[k*DW +: DW], exp_rd(ra[k*AW +: AW]));
  endtask

  task automatic random_cycle(input string tag, input bit with_writes);
    logic e0, e1;
    logic [AW-1:0] a0, a1, r0, r1;
    logic [DW-1:0] d0, d1;
    e0 = with_writes ? 1'($urandom_range(0, 1)) : 1'b0;
    e1 = with_writes ? 1'($urandom_range(0, 1)) : 1'b0;
    a0 = AW'($urandom_range(0, DEPTH - 1));
    a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, DEPTH - 1));
    r0 = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, DEPTH - 1));
    r1 = ($urandom_range(0, 2) == 0) ? a1 : AW'($urandom_range(0, DEPTH - 1));
    d0 = $urandom;
    d1 = $urandom;
    applyStimulus(1'b0, e0, a0, d0, e1, a1, d1, {r1, r0});
    checkOutput(tag);
    tick();
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    tick();
    tick();
    checkOutput("reset");

    // Ready must stay low for exactly DEPTH edges after release.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {5'd1, 5'd0});
    for (int i = 0; i < DEPTH; i++) begin
      check("clear_ready_low", {31'b0, ready}, 32'd0);
      tick();
    end
    check("ready_after_depth", {31'b0, ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {AW'(DEPTH - 1 - i), AW'(i)});
      check("cleared_p0", rd[0 +: DW], 32'd0);
      check("cleared_p1", rd[DW +: DW], 32'd0);
    end

    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, {5'd0, 5'd0});
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {5'd0, 5'd0});
    check("zero_reg_p0", rd[0 +: DW], 32'h0);
    check("zero_reg_p1", rd[DW +: DW], 32'h0);

    applyStimulus(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222, {5'd5, 5'd5});
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {5'd5, 5'd5});
    check("prio_p0", rd[0 +: DW], 32'h2222_2222);
    check("prio_p1", rd[DW +: DW], 32'h2222_2222);

    applyStimulus(1'b0, 1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd4, 32'h4444_4444, {5'd4, 5'd3});
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {5'd4, 5'd3});
    check("dual_addr3", rd[0 +: DW], 32'h3333_3333);
    check("dual_addr4", rd[DW +: DW], 32'h4444_4444);

    applyStimulus(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, '0, '0, {5'd0, 5'd7});
`ifdef REG_FILE_MP_BYPASS_EN
    check("same_cycle_read", rd[0 +: DW], 32'hDEAD_BEEF);
`else
    check("same_cycle_read", rd[0 +: DW], 32'h0);
`endif
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {5'd0, 5'd7});
    check("after_edge_read", rd[0 +: DW], 32'hDEAD_BEEF);

    repeat (300) random_cycle("random", 1'b1);

    // Reset pulse at clear index 10 with writes hammering the ports.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    tick();
    for (int i = 0; i < 10; i++) random_cycle("clear_part", 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd2, 32'h5555_5555, 1'b0, '0, '0, '0);
    tick();
    check("restart_ready_low", {31'b0, ready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, AW'(i), 32'hCAFE_0000 | DW'(i), 1'b1, AW'(DEPTH - 1 - i),
                    32'hBEEF_0000 | DW'(i), {AW'(i), AW'(DEPTH - 1 - i)});
      check("restart_not_ready", {31'b0, ready}, 32'd0);
      checkOutput("restart_clear");
      tick();
    end
    check("restart_ready_high", {31'b0, ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {AW'(i), AW'(i)});
      check("clear_writes_ignored", rd[0 +: DW], 32'h0);
    end

    repeat (100) random_cycle("random2", 1'b1);

    applyStimulus(1'b0, 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, '0, '0, {5'd9, 5'd9});
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {5'd9, 5'd9});
    check("addr9_written", rd[0 +: DW], 32'hA5A5_A5A5);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, {5'd9, 5'd9});
    checkOutput("rst_pre_edge");
    tick();
    check("rst_rd0_zero", rd[0 +: DW], 32'h0);
    check("rst_rd1_zero", rd[DW +: DW], 32'h0);
    check("rst_ready_low", {31'b0, ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {5'd9, 5'd9});
    for (int i = 0; i < DEPTH; i++) tick();
    checkOutput("post_reset");
    check("addr9_cleared", rd[0 +: DW], 32'h0);

    repeat (50) random_cycle("random3", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
